// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle control sequencer for a MIPS subset (R-type add/sub/and/or/
// slt/nor, lw, sw, beq, addi, j). Drives the registered ALU's control code
// and the datapath selects/strobes. Every ALU operation is issued one state
// before the state that consumes ALU out.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op, funct             IR[31:26] / IR[5:0], used in DECODE and EXEC only
//   alu_zero, mem_ready   datapath zero flag, memory access completion
//   alu_ctrl              ALU operation code
//   alu_src_a/alu_src_b   ALU operand selects
//   i_or_d                memory address select (PC / ALU out)
//   mem_read, mem_write, ir_write, reg_write, target_write   strobes
//   reg_dst, mem_to_reg   register-file write address / data selects
//   pc_en, pc_src         PC load enable and source select
//   illegal               one-cycle pulse on unsupported op/funct
//   state                 current state encoding (debug)
module alu_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic [3:0] alu_ctrl,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       target_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_EXEC    = 4'd2;
   localparam logic [3:0] S_RWB     = 4'd3;
   localparam logic [3:0] S_MEMRD   = 4'd4;
   localparam logic [3:0] S_LWB     = 4'd5;
   localparam logic [3:0] S_MEMWR   = 4'd6;
   localparam logic [3:0] S_IWB     = 4'd7;
   localparam logic [3:0] S_BR_TGT  = 4'd8;
   localparam logic [3:0] S_BR_CMP  = 4'd9;
   localparam logic [3:0] S_BR_DONE = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // R-type funct to ALU code; unknown functs fall back to ADD
   function automatic logic [3:0] rtype_ctrl(input logic [5:0] f);
      logic [3:0] c;
      case (f)
         6'b100000: c = ALU_ADD;
         6'b100010: c = ALU_SUB;
         6'b100100: c = ALU_AND;
         6'b100101: c = ALU_OR;
         6'b101010: c = ALU_SLT;
         6'b100111: c = ALU_NOR;
         default:   c = ALU_ADD;
      endcase
      return c;
   endfunction

   // True for the six supported R-type functs
   function automatic logic rtype_legal(input logic [5:0] f);
      logic ok;
      case (f)
         6'b100000, 6'b100010, 6'b100100,
         6'b100101, 6'b101010, 6'b100111: ok = 1'b1;
         default:                         ok = 1'b0;
      endcase
      return ok;
   endfunction

   logic [3:0] state_r;
   logic [3:0] next_s;

   // State register; reset lands in FETCH immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Moore output decode and next-state logic
   always_comb begin
      alu_ctrl     = ALU_ADD;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b01;
      i_or_d       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      target_write = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      pc_en        = 1'b0;
      pc_src       = 2'b00;
      illegal      = 1'b0;
      next_s       = S_FETCH;
      case (state_r)
         S_FETCH: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
            next_s   = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // PC+4 was computed by the ALU during FETCH
            pc_en = 1'b1;
            case (op)
               OP_RTYPE: begin
                  if (rtype_legal(funct)) begin
                     next_s = S_EXEC;
                  end else begin
                     illegal = 1'b1;
                     next_s  = S_FETCH;
                  end
               end
               OP_LW, OP_SW, OP_ADDI: next_s = S_EXEC;
               OP_BEQ:                next_s = S_BR_TGT;
               OP_J:                  next_s = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  next_s  = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            if (op == OP_RTYPE) begin
               alu_src_b = 2'b00;
               alu_ctrl  = rtype_ctrl(funct);
               next_s    = S_RWB;
            end else begin
               alu_src_b = 2'b10;
               case (op)
                  OP_LW:   next_s = S_MEMRD;
                  OP_SW:   next_s = S_MEMWR;
                  OP_ADDI: next_s = S_IWB;
                  default: next_s = S_FETCH;
               endcase
            end
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_MEMRD: begin
            // Keep recomputing A+sext(imm) so ALU out holds the address
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            mem_read  = 1'b1;
            i_or_d    = 1'b1;
            next_s    = mem_ready ? S_LWB : S_MEMRD;
         end
         S_LWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            next_s    = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_IWB: begin
            reg_write = 1'b1;
         end
         S_BR_TGT: begin
            // PC (already PC+4) + offset<<2
            alu_src_b = 2'b11;
            next_s    = S_BR_CMP;
         end
         S_BR_CMP: begin
            // Branch target is in ALU out now; compare A-B for BR_DONE
            target_write = 1'b1;
            alu_src_a    = 1'b1;
            alu_src_b    = 2'b00;
            alu_ctrl     = ALU_SUB;
            next_s       = S_BR_DONE;
         end
         S_BR_DONE: begin
            pc_en  = alu_zero;
            pc_src = 2'b10;
         end
         S_JUMP: begin
            pc_en  = 1'b1;
            pc_src = 2'b01;
         end
         default: begin
            next_s = S_FETCH;
         end
      endcase
   end

   assign state = state_r;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control sequencer that drives the registered ALU's 4-bit `ctrl` code and the surrounding datapath selects for the MIPS subset: R-type add/sub/and/or/slt/nor, lw, sw, beq, addi and j. It sits between instruction memory/IR and the datapath. Every ALU operation is issued one cycle before its result is consumed, which matches the ALU's one-clock output register. Memory accesses use a ready handshake.

## Interface
- (no parameters; all encodings fixed)
- `clk`  in  1  sole clock; all state changes on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `op`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `alu_zero`  in  1  datapath flag: ALU out == 0
- `mem_ready`  in  1  memory completes the current access this cycle
- `alu_ctrl`  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- `alu_src_a`  out  1  0 = PC, 1 = reg A
- `alu_src_b`  out  2  00 = reg B, 01 = const 4, 10 = sext(imm), 11 = sext(imm)<<2
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALU out
- `mem_read`, `mem_write`, `ir_write`, `reg_write`, `target_write`  out  1 each
- `reg_dst`  out  1  0 = rt, 1 = rd
- `mem_to_reg`  out  1  0 = ALU out, 1 = MDR
- `pc_en`  out  1  PC load this cycle
- `pc_src`  out  2  00 = ALU out, 01 = jump target {PC[31:28], IR[25:0], 00}, 10 = branch target register
- `illegal`  out  1  one-cycle pulse on an unsupported op/funct
- `state`  out  4  current state encoding, for debug

## Operation
- Outputs decode from the state register. `ir_write` and `pc_en` are additionally qualified as noted below.
- Default in every state: `alu_ctrl`=0010, `alu_src_a`=0, `alu_src_b`=01. All strobes are 0 unless listed.
- States and encodings:
  - FETCH 0: `mem_read`=1, `i_or_d`=0. `ir_write`=`mem_ready`. Stay in FETCH while `mem_ready`=0; otherwise go to DECODE.
  - DECODE 1: `pc_en`=1, `pc_src`=00 (loads PC+4 computed in FETCH).
    - op 000000 with a legal funct → EXEC.
    - op 100011, 101011 or 001000 → EXEC.
    - op 000100 → BR_TGT.
    - op 000010 → JUMP.
    - Anything else: `illegal`=1 → FETCH.
  - EXEC 2:
    - R-type: `alu_src_a`=1, `alu_src_b`=00. funct 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111→1100. Next state RWB.
    - lw/sw/addi: `alu_src_a`=1, `alu_src_b`=10, ADD. Next state MEMRD, MEMWR or IWB respectively.
  - RWB 3: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
  - MEMRD 4: `mem_read`=1, `i_or_d`=1. Hold until `mem_ready`, then → LWB.
  - LWB 5: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
  - MEMWR 6: `mem_write`=1, `i_or_d`=1. Hold until `mem_ready`, then → FETCH.
  - IWB 7: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
  - BR_TGT 8: `alu_src_b`=11, ADD (PC+4 + offset) → BR_CMP.
  - BR_CMP 9: `target_write`=1 (captures the target), `alu_src_a`=1, `alu_src_b`=00, SUB → BR_DONE.
  - BR_DONE 10: `pc_en`=`alu_zero`, `pc_src`=10 → FETCH.
  - JUMP 11: `pc_en`=1, `pc_src`=01 → FETCH.
- Codes 12–15 are unreachable. If entered, they decode as the default outputs and go to FETCH next cycle.
- While MEMRD or MEMWR is held waiting on `mem_ready`, `alu_ctrl` must be ADD with `alu_src_b`=10, so the address held in ALU out is recomputed unchanged.

## Timing
- Reset (async assert, sync-safe deassert): `state`=FETCH immediately. Outputs then read `mem_read`=1, `alu_ctrl`=0010, `alu_src_a`=0, `alu_src_b`=01; all other outputs 0. `ir_write` follows `mem_ready`.
- `rst_n` asserted mid-instruction aborts it the same instant. No strobe stays high after assertion except the FETCH defaults.
- ALU result driven in state N is valid as ALU out in state N+1. Every consumer state above is placed on that basis.
- Cycles per instruction with zero-wait memory: j 3, R-type 4, addi 4, sw 4, lw 5, beq 5, illegal 2. Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- `op` and `funct` are sampled combinationally in DECODE and EXEC only. The IR must hold them stable until FETCH.

## Test plan
- Reset: `rst_n`=0 with `mem_ready`=1 → `state`=0, `mem_read`=1, `alu_ctrl`=0010, `ir_write`=1, `pc_en`=0.
- R-type sweep, funct 100000/100010/100100/100101/101010/100111 → EXEC shows `alu_ctrl` 0010/0110/0000/0001/0111/1100; RWB shows `reg_write`=1, `reg_dst`=1; 4 cycles each.
- lw with `mem_ready` low for 2 cycles in MEMRD → state trace 0,1,2,4,4,4,5,0 (7 cycles); `i_or_d`=1 throughout MEMRD; `mem_to_reg`=1 in LWB.
- beq, `alu_zero`=1 in BR_DONE → `pc_en`=1, `pc_src`=10. Repeat with `alu_zero`=0 → `pc_en`=0. Both take 5 cycles with `target_write` pulsed in BR_CMP.
- op 111111 → `illegal`=1 for exactly one cycle in DECODE, `pc_en`=1 there, then back to FETCH.
- Assert `rst_n`=0 during MEMWR with `mem_ready`=0 → `mem_write` drops at once, `state`=0. After release the next instruction completes normally.
